// File: rtl/mc_ctrl_pkg.sv
// Purpose : shared encodings for the multi-cycle MIPS main controller
//           (FSM states, opcodes, R-type funct codes, alu operation codes).
// Latency : n/a (types, constants and pure decode helpers only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE_R  = 4'd2,
    S_WB_R   = 4'd3,
    S_EXE_I  = 4'd4,
    S_WB_I   = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_MEM_WR = 4'd8,
    S_WB_LW  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef logic [3:0] alu_ctr_t;

  // Opcodes, ins[31:26]
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct, ins[5:0]
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // alu operation codes
  localparam alu_ctr_t ALU_AND = 4'b0000;
  localparam alu_ctr_t ALU_OR  = 4'b0001;
  localparam alu_ctr_t ALU_ADD = 4'b0010;
  localparam alu_ctr_t ALU_SUB = 4'b0110;
  localparam alu_ctr_t ALU_SLT = 4'b0111;

  function automatic logic funct_ok(input logic [5:0] funct);
    logic ok;
    case (funct)
      FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

  // State that follows DECODE. S_FETCH means the instruction is not
  // supported and must be dropped.
  function automatic state_t decode_next(input logic [5:0] op,
                                         input logic [5:0] funct);
    state_t s;
    case (op)
      OP_R:             s = funct_ok(funct) ? S_EXE_R : S_FETCH;
      OP_ORI, OP_ADDIU: s = S_EXE_I;
      OP_LW, OP_SW:     s = S_ADDR;
      OP_BEQ:           s = S_BRANCH;
      OP_J:             s = S_JUMP;
      default:          s = S_FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Purpose : controller <-> datapath bundle: instruction fields, status
//           flags, all control strobes and controller status.
// Latency : n/a (wiring only).  Backpressure: mem_ready stalls the controller.
// Ports   : master = controller (drives strobes), slave = datapath side.
interface mc_ctrl_if
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  // datapath -> controller
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;

  // controller -> datapath
  logic             irWr;
  logic             pcEn;
  logic             branch;
  logic             jump;
  logic             regDst;
  logic             aluSrc;
  logic             extOp;
  logic             regWr;
  logic             memWr;
  logic             memRd;
  logic             memtoReg;
  alu_ctr_t         aluCtr;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, funct, zero, mem_ready,
    output irWr, pcEn, branch, jump, regDst, aluSrc, extOp, regWr,
           memWr, memRd, memtoReg, aluCtr, illegal, timeout, retired
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  irWr, pcEn, branch, jump, regDst, aluSrc, extOp, regWr,
           memWr, memRd, memtoReg, aluCtr, illegal, timeout, retired
  );

endinterface

// File: rtl/mc_alu_dec.sv
// Purpose : alu operation decode from (latched) opcode and funct.
// Latency : combinational, 0 cycles.  Backpressure: none.
// Ports   : op, funct in; alu_ctr out (ADD for anything not listed).
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output alu_ctr_t   alu_ctr
);

  always_comb begin
    alu_ctr = ALU_ADD;
    case (op)
      OP_R: begin
        case (funct)
          FN_SUBU: alu_ctr = ALU_SUB;
          FN_AND:  alu_ctr = ALU_AND;
          FN_OR:   alu_ctr = ALU_OR;
          FN_SLT:  alu_ctr = ALU_SLT;
          default: alu_ctr = ALU_ADD;
        endcase
      end
      OP_ORI:  alu_ctr = ALU_OR;
      OP_BEQ:  alu_ctr = ALU_SUB;
      default: alu_ctr = ALU_ADD;  // ADDIU, LW/SW address, J
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Purpose : multi-cycle MIPS main controller (FETCH/DECODE/EXE/MEM/WB),
//           retired-instruction counter, illegal and memory-timeout pulses.
// Latency : R/I/SW 4 cycles, LW 5, BEQ/J 3 (mem_ready high); illegal 2.
// Backpressure: MEM_RD/MEM_WR hold until mem_ready or the wait limit.
// Ports   : clk, rst (async, active high), bus (mc_ctrl_if.master).
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam bit WAIT_EN = (MEM_WAIT_MAX > 0);
  // Last permitted wait cycle: the access is abandoned when this cycle
  // also ends without mem_ready, so a MEM state lasts at most
  // MEM_WAIT_MAX cycles.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_WAIT_MAX > 0) ? (MEM_WAIT_MAX - 1) : 0);

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [5:0]        funct_q, funct_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic              retire;
  logic              mem_expire;
  alu_ctr_t          dec_alu;

  mc_alu_dec u_alu_dec (
    .op      (op_q),
    .funct   (funct_q),
    .alu_ctr (dec_alu)
  );

  // Next-state, latch and counter logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    funct_d    = funct_q;
    wait_cnt_d = wait_cnt_q;
    retired_d  = retired_q;
    illegal_d  = 1'b0;
    timeout_d  = 1'b0;
    retire     = 1'b0;
    mem_expire = WAIT_EN && (wait_cnt_q == WAIT_LAST) && !bus.mem_ready;

    case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        op_d      = bus.op;
        funct_d   = bus.funct;
        state_d   = decode_next(bus.op, bus.funct);
        illegal_d = (decode_next(bus.op, bus.funct) == S_FETCH);
      end

      S_EXE_R: state_d = S_WB_R;
      S_EXE_I: state_d = S_WB_I;

      S_ADDR: begin
        state_d    = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
        wait_cnt_d = '0;
      end

      S_MEM_RD, S_MEM_WR: begin
        // mem_ready takes priority over an expiring wait limit
        if (bus.mem_ready) begin
          if (state_q == S_MEM_RD) begin
            state_d = S_WB_LW;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (mem_expire) begin
          state_d   = S_FETCH;
          timeout_d = 1'b1;
        end else if (WAIT_EN) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_WB_R, S_WB_I, S_WB_LW, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end

      default: state_d = S_FETCH;
    endcase

    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      op_q       <= '0;
      funct_q    <= '0;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      funct_q    <= funct_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  // Moore strobes decoded from the state register and latched op/funct.
  // Gating with rst makes every strobe drop the moment rst rises, while
  // the FETCH strobes are already present in the first cycle after release.
  always_comb begin
    bus.irWr     = 1'b0;
    bus.pcEn     = 1'b0;
    bus.branch   = 1'b0;
    bus.jump     = 1'b0;
    bus.regDst   = 1'b0;
    bus.aluSrc   = 1'b0;
    bus.extOp    = 1'b0;
    bus.regWr    = 1'b0;
    bus.memWr    = 1'b0;
    bus.memRd    = 1'b0;
    bus.memtoReg = 1'b0;
    bus.aluCtr   = ALU_ADD;

    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.irWr = 1'b1;
          bus.pcEn = 1'b1;
        end
        S_EXE_R: begin
          bus.regDst = 1'b1;
          bus.aluCtr = dec_alu;
        end
        S_WB_R: begin
          bus.regDst = 1'b1;
          bus.regWr  = 1'b1;
          bus.aluCtr = dec_alu;
        end
        S_EXE_I: begin
          bus.aluSrc = 1'b1;
          bus.extOp  = (op_q == OP_ADDIU);
          bus.aluCtr = dec_alu;
        end
        S_WB_I: begin
          bus.aluSrc = 1'b1;
          bus.extOp  = (op_q == OP_ADDIU);
          bus.aluCtr = dec_alu;
          bus.regWr  = 1'b1;
        end
        S_ADDR: begin
          bus.aluSrc = 1'b1;
          bus.extOp  = 1'b1;
        end
        S_MEM_RD: begin
          bus.aluSrc = 1'b1;
          bus.extOp  = 1'b1;
          bus.memRd  = 1'b1;
        end
        S_MEM_WR: begin
          bus.aluSrc = 1'b1;
          bus.extOp  = 1'b1;
          bus.memWr  = 1'b1;
        end
        S_WB_LW: begin
          bus.memtoReg = 1'b1;
          bus.regWr    = 1'b1;
        end
        S_BRANCH: begin
          bus.branch = 1'b1;
          bus.aluCtr = ALU_SUB;
          bus.pcEn   = bus.zero;  // only input-dependent strobe
        end
        S_JUMP: begin
          bus.jump = 1'b1;
          bus.pcEn = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.illegal = illegal_q;
  assign bus.timeout = timeout_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Purpose : directed self-checking bench for mc_ctrl.
// Latency : n/a.  Backpressure: mem_ready driven directly by the stimulus.
// Ports   : none (top-level bench).
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int CNT_W    = 32;
  localparam int WAIT_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mc_ctrl #(.CNT_W(CNT_W), .MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one cycle; sample 2 time units after the rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [5:0] fn_tab  [4] = '{6'b100011, 6'b100100, 6'b100101, 6'b101010};
  logic [3:0] alu_tab [4] = '{4'b0110,   4'b0000,   4'b0001,   4'b0111};

  initial begin
    int n;
    bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #3;
    chk("rst_irWr",    bus.irWr,    0);
    chk("rst_pcEn",    bus.pcEn,    0);
    chk("rst_aluCtr",  bus.aluCtr,  4'b0010);
    chk("rst_retired", bus.retired, 0);
    @(posedge clk); #2; rst = 1'b0; #1;

    // ADDU: c0 FETCH .. c3 WB_R, retired=1 at c4
    chk("addu_c0_irWr", bus.irWr, 1);
    chk("addu_c0_pcEn", bus.pcEn, 1);
    bus.op = 6'b000000; bus.funct = 6'b100001;
    step(); chk("addu_c1_irWr", bus.irWr, 0);
    step(); chk("addu_c2_regDst", bus.regDst, 1); chk("addu_c2_regWr", bus.regWr, 0);
    step();
    chk("addu_c3_regWr", bus.regWr, 1);
    chk("addu_c3_regDst", bus.regDst, 1);
    chk("addu_c3_aluCtr", bus.aluCtr, 4'b0010);
    step(); chk("addu_c4_retired", bus.retired, 1); chk("addu_c4_irWr", bus.irWr, 1);

    // remaining R-type functs
    for (int i = 0; i < 4; i++) begin
      bus.funct = fn_tab[i];
      step(); step();
      chk("rfn_aluCtr", bus.aluCtr, alu_tab[i]);
      chk("rfn_aluSrc", bus.aluSrc, 0);
      step(); step();
    end
    chk("rfn_retired", bus.retired, 5);

    // ORI then ADDIU
    bus.op = 6'b001101;
    step(); step();
    chk("ori_aluSrc", bus.aluSrc, 1); chk("ori_extOp", bus.extOp, 0);
    chk("ori_aluCtr", bus.aluCtr, 4'b0001);
    step(); chk("ori_wb_regWr", bus.regWr, 1); chk("ori_wb_regDst", bus.regDst, 0);
    step(); chk("ori_retired", bus.retired, 6);
    bus.op = 6'b001001;
    step(); step();
    chk("addiu_extOp", bus.extOp, 1); chk("addiu_aluCtr", bus.aluCtr, 4'b0010);
    step(); step(); chk("addiu_retired", bus.retired, 7);

    // LW with mem_ready low for 3 MEM_RD cycles
    bus.op = 6'b100011; bus.mem_ready = 1'b0;
    step(); step();
    chk("lw_addr_aluSrc", bus.aluSrc, 1); chk("lw_addr_extOp", bus.extOp, 1);
    chk("lw_addr_memRd", bus.memRd, 0);
    step();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.memRd) n++;
      bus.mem_ready = (i == 3);
      step();
    end
    chk("lw_memRd_cycles", n, 4);
    chk("lw_wb_memtoReg", bus.memtoReg, 1); chk("lw_wb_regWr", bus.regWr, 1);
    chk("lw_wb_memRd", bus.memRd, 0);
    step(); chk("lw_retired", bus.retired, 8);

    // SW, mem_ready already high
    bus.op = 6'b101011;
    step(); step(); step(); chk("sw_memWr", bus.memWr, 1);
    step(); chk("sw_retired", bus.retired, 9); chk("sw_fetch_memWr", bus.memWr, 0);

    // BEQ taken then not taken
    bus.op = 6'b000100; bus.zero = 1'b1;
    step(); step();
    chk("beq1_pcEn", bus.pcEn, 1); chk("beq1_branch", bus.branch, 1);
    chk("beq1_aluCtr", bus.aluCtr, 4'b0110);
    step(); chk("beq1_retired", bus.retired, 10);
    bus.zero = 1'b0;
    step(); step();
    chk("beq0_pcEn", bus.pcEn, 0); chk("beq0_branch", bus.branch, 1);
    step(); chk("beq0_retired", bus.retired, 11);

    // J
    bus.op = 6'b000010;
    step(); step(); chk("j_jump", bus.jump, 1); chk("j_pcEn", bus.pcEn, 1);
    step(); chk("j_retired", bus.retired, 12);

    // illegal opcode, then illegal R funct
    bus.op = 6'b111111;
    step(); chk("ill_dec_illegal", bus.illegal, 0); chk("ill_dec_regWr", bus.regWr, 0);
    step();
    chk("ill_illegal", bus.illegal, 1); chk("ill_irWr", bus.irWr, 1);
    chk("ill_memWr", bus.memWr, 0); chk("ill_retired", bus.retired, 12);
    bus.op = 6'b000000; bus.funct = 6'b000000;
    step(); step(); chk("illfn_illegal", bus.illegal, 1); chk("illfn_retired", bus.retired, 12);
    bus.funct = 6'b100001;
    step(); chk("ill_pulse_drop", bus.illegal, 0);
    step(); step(); step(); chk("ill_after_retired", bus.retired, 13);

    // SW timeout with mem_ready held low
    bus.op = 6'b101011; bus.mem_ready = 1'b0;
    step(); step(); step();
    n = 0;
    while (bus.memWr && n < 40) begin
      n++;
      step();
    end
    chk("to_wait_cycles", n, 15);
    chk("to_timeout", bus.timeout, 1); chk("to_irWr", bus.irWr, 1);
    chk("to_retired", bus.retired, 13);
    bus.op = 6'b000000; bus.funct = 6'b100001; bus.mem_ready = 1'b1;
    step(); chk("to_pulse_drop", bus.timeout, 0);
    step(); step(); step(); chk("to_after_retired", bus.retired, 14);

    // mem_ready arriving on the last permitted wait cycle wins
    bus.op = 6'b101011; bus.mem_ready = 1'b0;
    step(); step(); step();
    for (int i = 0; i < 15; i++) begin
      bus.mem_ready = (i == 14);
      step();
    end
    chk("lim_timeout", bus.timeout, 0); chk("lim_irWr", bus.irWr, 1);
    chk("lim_retired", bus.retired, 15);

    // async reset during MEM_WR
    bus.mem_ready = 1'b0;
    step(); step(); step(); chk("rmw_memWr", bus.memWr, 1);
    #2; rst = 1'b1; #1;
    chk("rmw_async_memWr", bus.memWr, 0); chk("rmw_async_aluSrc", bus.aluSrc, 0);
    chk("rmw_async_retired", bus.retired, 0);
    @(posedge clk); #2; rst = 1'b0; #1;
    chk("rmw_rel_irWr", bus.irWr, 1); chk("rmw_rel_memWr", bus.memWr, 0);
    chk("rmw_rel_retired", bus.retired, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
